// File: rtl/seq0237_if.sv
// Link between the 0->2->3->7 code source and the receive-side checker.
// The master side drives samples; the slave side returns lock and status.
interface seq0237_if #(
  parameter int CNT_W = 8
) ();
  logic             in_valid;
  logic [2:0]       in_code;
  logic             locked;
  logic             err_pulse;
  logic             illegal;
  logic [2:0]       expected;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] cyc_count;

  modport master (
    output in_valid, in_code,
    input  locked, err_pulse, illegal, expected, err_count, cyc_count
  );

  modport slave (
    input  in_valid, in_code,
    output locked, err_pulse, illegal, expected, err_count, cyc_count
  );
endinterface

// File: rtl/seq0237_checker.sv
// Receive-side checker for the cyclic 0->2->3->7 code: hunts for a 0, confirms
// LOCK_N in-order codes, then flywheels through errors until UNLOCK_N misses.
module seq0237_checker #(
  parameter int LOCK_N   = 3,
  parameter int UNLOCK_N = 2,
  parameter int CNT_W    = 8
) (
  input logic      clk,
  input logic      rst,
  seq0237_if.slave bus
);

  localparam int MW = (LOCK_N > 1) ? $clog2(LOCK_N + 1) : 1;
  localparam int UW = (UNLOCK_N > 1) ? $clog2(UNLOCK_N + 1) : 1;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           r_state,     w_state_next;
  logic             r_locked,    w_locked_next;
  logic             r_err_pulse, w_err_pulse_next;
  logic             r_illegal,   w_illegal_next;
  logic [2:0]       r_expected,  w_expected_next;
  logic [CNT_W-1:0] r_err_count, w_err_count_next;
  logic [CNT_W-1:0] r_cyc_count, w_cyc_count_next;
  logic [MW-1:0]    r_match_cnt, w_match_cnt_next;
  logic [UW-1:0]    r_miss_cnt,  w_miss_cnt_next;

  logic [MW-1:0]    w_match_inc;
  logic [UW-1:0]    w_miss_inc;
  logic             w_code_illegal;

  function automatic logic [2:0] f_nxt(input logic [2:0] c);
    case (c)
      3'd0:    f_nxt = 3'd2;
      3'd2:    f_nxt = 3'd3;
      3'd3:    f_nxt = 3'd7;
      default: f_nxt = 3'd0;
    endcase
  endfunction

  assign w_match_inc    = r_match_cnt + MW'(1);
  assign w_miss_inc     = r_miss_cnt + UW'(1);
  assign w_code_illegal = (bus.in_code == 3'd1) || (bus.in_code == 3'd4) ||
                          (bus.in_code == 3'd5) || (bus.in_code == 3'd6);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= HUNT;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_illegal   <= 1'b0;
      r_expected  <= 3'd0;
      r_err_count <= '0;
      r_cyc_count <= '0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_locked    <= w_locked_next;
      r_err_pulse <= w_err_pulse_next;
      r_illegal   <= w_illegal_next;
      r_expected  <= w_expected_next;
      r_err_count <= w_err_count_next;
      r_cyc_count <= w_cyc_count_next;
      r_match_cnt <= w_match_cnt_next;
      r_miss_cnt  <= w_miss_cnt_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_locked_next    = r_locked;
    w_err_pulse_next = 1'b0;
    w_illegal_next   = 1'b0;
    w_expected_next  = r_expected;
    w_err_count_next = r_err_count;
    w_cyc_count_next = r_cyc_count;
    w_match_cnt_next = r_match_cnt;
    w_miss_cnt_next  = r_miss_cnt;

    if (bus.in_valid) begin
      w_illegal_next = w_code_illegal;
      case (r_state)
        HUNT: begin
          if (bus.in_code == 3'd0) begin
            w_expected_next = 3'd2;
            if (LOCK_N == 1) begin
              w_state_next    = LOCKED;
              w_locked_next   = 1'b1;
              w_miss_cnt_next = '0;
            end else begin
              w_state_next     = SYNC;
              w_match_cnt_next = MW'(1);
            end
          end
        end

        SYNC: begin
          if (bus.in_code == r_expected) begin
            w_match_cnt_next = w_match_inc;
            w_expected_next  = f_nxt(bus.in_code);
            if (w_match_inc == MW'(LOCK_N)) begin
              w_state_next    = LOCKED;
              w_locked_next   = 1'b1;
              w_miss_cnt_next = '0;
            end
          end else if (bus.in_code == 3'd0) begin
            w_match_cnt_next = MW'(1);
            w_expected_next  = 3'd2;
          end else begin
            w_state_next     = HUNT;
            w_match_cnt_next = '0;
            w_expected_next  = 3'd0;
          end
        end

        LOCKED: begin
          if (bus.in_code == r_expected) begin
            w_miss_cnt_next = '0;
            w_expected_next = f_nxt(r_expected);
            if (bus.in_code == 3'd7) begin
              w_cyc_count_next = r_cyc_count + CNT_W'(1);
            end
          end else begin
            w_err_pulse_next = 1'b1;
            if (r_err_count != {CNT_W{1'b1}}) begin
              w_err_count_next = r_err_count + CNT_W'(1);
            end
            // Flywheel: advance past the bad code instead of resyncing on it.
            if (w_miss_inc == UW'(UNLOCK_N)) begin
              w_state_next     = HUNT;
              w_locked_next    = 1'b0;
              w_expected_next  = 3'd0;
              w_miss_cnt_next  = '0;
              w_match_cnt_next = '0;
            end else begin
              w_miss_cnt_next = w_miss_inc;
              w_expected_next = f_nxt(r_expected);
            end
          end
        end

        default: begin
          w_state_next    = HUNT;
          w_locked_next   = 1'b0;
          w_expected_next = 3'd0;
        end
      endcase
    end
  end

  assign bus.locked    = r_locked;
  assign bus.err_pulse = r_err_pulse;
  assign bus.illegal   = r_illegal;
  assign bus.expected  = r_expected;
  assign bus.err_count = r_err_count;
  assign bus.cyc_count = r_cyc_count;

endmodule

// File: tb/tb_seq0237_checker.sv
// Bench for seq0237_checker: two instances (CNT_W=8 and CNT_W=2) share one
// stimulus stream; a scoreboard compares every response, tasks add scenario checks.
module tb_seq0237_checker;

  localparam int LOCK_N   = 3;
  localparam int UNLOCK_N = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  always #5 clk = ~clk;

  seq0237_if #(.CNT_W(8)) bus_a ();
  seq0237_if #(.CNT_W(2)) bus_b ();

  seq0237_checker #(.LOCK_N(LOCK_N), .UNLOCK_N(UNLOCK_N), .CNT_W(8)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  seq0237_checker #(.LOCK_N(LOCK_N), .UNLOCK_N(UNLOCK_N), .CNT_W(2)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  typedef struct {
    int st;   // 0 hunt, 1 sync, 2 locked
    int ex;
    int mc;
    int mm;
    int errc;
    int cycc;
    bit lk;
    bit ep;
    bit il;
  } model_t;

  model_t ma, mb;
  model_t qa[$];
  model_t qb[$];

  function automatic int succ(input int c);
    int tab [8] = '{2, 0, 3, 7, 0, 0, 0, 0};
    return tab[c];
  endfunction

  function automatic model_t model_step(input model_t m, input bit r, input bit v,
                                        input int c, input int cmax);
    model_t n = m;
    n.ep = 0;
    n.il = 0;
    if (!r) begin
      n.st = 0; n.ex = 0; n.mc = 0; n.mm = 0; n.errc = 0; n.cycc = 0; n.lk = 0;
      return n;
    end
    if (!v) return n;
    n.il = (c == 1) || (c == 4) || (c == 5) || (c == 6);
    if (m.st == 0) begin
      if (c == 0) begin
        n.ex = 2;
        if (LOCK_N == 1) begin n.st = 2; n.lk = 1; n.mm = 0; end
        else begin n.st = 1; n.mc = 1; end
      end
    end else if (m.st == 1) begin
      if (c == m.ex) begin
        n.mc = m.mc + 1;
        n.ex = succ(c);
        if (n.mc == LOCK_N) begin n.st = 2; n.lk = 1; n.mm = 0; end
      end else if (c == 0) begin
        n.mc = 1; n.ex = 2;
      end else begin
        n.st = 0; n.mc = 0; n.ex = 0;
      end
    end else begin
      if (c == m.ex) begin
        n.mm = 0;
        n.ex = succ(m.ex);
        if (c == 7) n.cycc = (m.cycc + 1) % (cmax + 1);
      end else begin
        n.ep = 1;
        n.errc = (m.errc < cmax) ? m.errc + 1 : m.errc;
        n.mm = m.mm + 1;
        n.ex = succ(m.ex);
        if (n.mm == UNLOCK_N) begin n.st = 0; n.lk = 0; n.ex = 0; n.mm = 0; n.mc = 0; end
      end
    end
    return n;
  endfunction

  // Drive one cycle on both instances and queue the expected responses.
  task automatic step(input bit r, input bit v, input logic [2:0] c);
    @(negedge clk);
    rst = r;
    bus_a.in_valid = v; bus_a.in_code = c;
    bus_b.in_valid = v; bus_b.in_code = c;
    ma = model_step(ma, r, v, int'(c), 255);
    mb = model_step(mb, r, v, int'(c), 3);
    qa.push_back(ma);
    qb.push_back(mb);
    step_no++;
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    model_t ea, eb;
    #1;
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      checks++;
      if ({bus_a.locked, bus_a.err_pulse, bus_a.illegal, bus_a.expected, bus_a.err_count, bus_a.cyc_count}
          !== {ea.lk, ea.ep, ea.il, 3'(ea.ex), 8'(ea.errc), 8'(ea.cycc)}) begin
        errors++;
        $display("FAIL sb_a step=%0d got lk=%b ep=%b il=%b exp=%0d err=%0d cyc=%0d want lk=%b ep=%b il=%b exp=%0d err=%0d cyc=%0d",
                 step_no, bus_a.locked, bus_a.err_pulse, bus_a.illegal, bus_a.expected, bus_a.err_count,
                 bus_a.cyc_count, ea.lk, ea.ep, ea.il, ea.ex, ea.errc, ea.cycc);
      end
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      checks++;
      if ({bus_b.locked, bus_b.err_pulse, bus_b.illegal, bus_b.expected, bus_b.err_count, bus_b.cyc_count}
          !== {eb.lk, eb.ep, eb.il, 3'(eb.ex), 2'(eb.errc), 2'(eb.cycc)}) begin
        errors++;
        $display("FAIL sb_b step=%0d got lk=%b ep=%b il=%b exp=%0d err=%0d cyc=%0d want lk=%b ep=%b il=%b exp=%0d err=%0d cyc=%0d",
                 step_no, bus_b.locked, bus_b.err_pulse, bus_b.illegal, bus_b.expected, bus_b.err_count,
                 bus_b.cyc_count, eb.lk, eb.ep, eb.il, eb.ex, eb.errc, eb.cycc);
      end
    end
  end

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      checks++;
      if ({bus_a.locked, bus_a.err_pulse, bus_a.illegal, bus_a.expected, bus_a.err_count, bus_a.cyc_count} !== 16'd0) begin
        errors++;
        $display("FAIL reset i=%0d got lk=%b ep=%b il=%b exp=%0d err=%0d cyc=%0d want all zero",
                 i, bus_a.locked, bus_a.err_pulse, bus_a.illegal, bus_a.expected, bus_a.err_count, bus_a.cyc_count);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_lock();
    step(1, 1, 3'd0);
    step(1, 1, 3'd2);
    checks++;
    if (bus_a.locked !== 1'b0) begin errors++; $display("FAIL lock_early got=%b want=0", bus_a.locked); end
    step(1, 1, 3'd3);
    checks++;
    if ({bus_a.locked, bus_a.expected} !== {1'b1, 3'd7}) begin
      errors++; $display("FAIL lock got lk=%b exp=%0d want lk=1 exp=7", bus_a.locked, bus_a.expected);
    end
    step(1, 1, 3'd7);
    checks++;
    if (bus_a.cyc_count !== 8'd1) begin errors++; $display("FAIL lock_cyc got=%0d want=1", bus_a.cyc_count); end
    $display("test_lock done");
  endtask

  task automatic test_flywheel();
    step(1, 1, 3'd0);
    step(1, 1, 3'd2);
    step(1, 1, 3'd5);
    checks++;
    if ({bus_a.illegal, bus_a.err_pulse, bus_a.locked, bus_a.err_count} !== {3'b111, 8'd1}) begin
      errors++;
      $display("FAIL flywheel_err got il=%b ep=%b lk=%b err=%0d want il=1 ep=1 lk=1 err=1",
               bus_a.illegal, bus_a.err_pulse, bus_a.locked, bus_a.err_count);
    end
    step(1, 1, 3'd7);
    checks++;
    if ({bus_a.illegal, bus_a.err_pulse, bus_a.locked, bus_a.cyc_count} !== {3'b001, 8'd2}) begin
      errors++;
      $display("FAIL flywheel_7 got il=%b ep=%b lk=%b cyc=%0d want il=0 ep=0 lk=1 cyc=2",
               bus_a.illegal, bus_a.err_pulse, bus_a.locked, bus_a.cyc_count);
    end
    $display("test_flywheel done");
  endtask

  task automatic test_unlock();
    step(1, 1, 3'd0);   // now expecting 2
    step(1, 1, 3'd3);   // miss, flywheel expects 3
    checks++;
    if ({bus_a.err_pulse, bus_a.locked, bus_a.expected} !== {2'b11, 3'd3}) begin
      errors++; $display("FAIL unlock_first got ep=%b lk=%b exp=%0d want ep=1 lk=1 exp=3",
                         bus_a.err_pulse, bus_a.locked, bus_a.expected);
    end
    step(1, 1, 3'd2);   // second miss drops lock
    checks++;
    if ({bus_a.err_pulse, bus_a.locked, bus_a.expected, bus_a.err_count} !== {2'b10, 3'd0, 8'd3}) begin
      errors++; $display("FAIL unlock_second got ep=%b lk=%b exp=%0d err=%0d want ep=1 lk=0 exp=0 err=3",
                         bus_a.err_pulse, bus_a.locked, bus_a.expected, bus_a.err_count);
    end
    $display("test_unlock done");
  endtask

  task automatic test_gaps_resync();
    step(1, 1, 3'd0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 3'($urandom_range(0, 7)));
      checks++;
      if ({bus_a.locked, bus_a.expected} !== {1'b0, 3'd2}) begin
        errors++; $display("FAIL gap i=%0d got lk=%b exp=%0d want lk=0 exp=2", i, bus_a.locked, bus_a.expected);
      end
    end
    step(1, 1, 3'd2);
    step(1, 1, 3'd0);
    checks++;
    if (bus_a.expected !== 3'd2) begin errors++; $display("FAIL resync_restart got=%0d want=2", bus_a.expected); end
    step(1, 1, 3'd2);
    step(1, 1, 3'd3);
    checks++;
    if ({bus_a.locked, bus_a.err_count} !== {1'b1, 8'd3}) begin
      errors++; $display("FAIL resync_lock got lk=%b err=%0d want lk=1 err=3", bus_a.locked, bus_a.err_count);
    end
    $display("test_gaps_resync done");
  endtask

  task automatic test_saturation();
    step(0, 0, 3'd0);
    step(1, 1, 3'd0); step(1, 1, 3'd2); step(1, 1, 3'd3); step(1, 1, 3'd7);
    for (int k = 0; k < 4; k++) begin
      step(1, 1, 3'd0); step(1, 1, 3'd2); step(1, 1, 3'd3); step(1, 1, 3'd7);
    end
    checks++;
    if ({bus_a.cyc_count, bus_b.cyc_count} !== {8'd5, 2'd1}) begin
      errors++; $display("FAIL cyc_wrap got a=%0d b=%0d want a=5 b=1", bus_a.cyc_count, bus_b.cyc_count);
    end
    step(1, 1, 3'd1); step(1, 1, 3'd4);
    for (int k = 0; k < 2; k++) begin
      step(1, 1, 3'd0); step(1, 1, 3'd2); step(1, 1, 3'd3);
      step(1, 1, 3'd6); step(1, 1, 3'd5);
    end
    checks++;
    if ({bus_a.err_count, bus_b.err_count} !== {8'd6, 2'd3}) begin
      errors++; $display("FAIL err_sat got a=%0d b=%0d want a=6 b=3", bus_a.err_count, bus_b.err_count);
    end
    step(1, 1, 3'd0); step(1, 1, 3'd2);
    step(0, 1, 3'd3);
    step(1, 1, 3'd3);
    checks++;
    if ({bus_a.locked, bus_a.expected, bus_a.err_count, bus_b.cyc_count} !== {1'b0, 3'd0, 8'd0, 2'd0}) begin
      errors++; $display("FAIL mid_sync_reset got lk=%b exp=%0d err=%0d cyc_b=%0d want 0 0 0 0",
                         bus_a.locked, bus_a.expected, bus_a.err_count, bus_b.cyc_count);
    end
    $display("test_saturation done");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      logic [2:0] c;
      c = ($urandom_range(0, 3) != 0) ? 3'(ma.ex) : 3'($urandom_range(0, 7));
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 4) != 0), c);
    end
    $display("test_back_to_back done");
  endtask

  initial begin
    bus_a.in_valid = 1'b0; bus_a.in_code = 3'd0;
    bus_b.in_valid = 1'b0; bus_b.in_code = 3'd0;
    test_reset();
    test_lock();
    test_flywheel();
    test_unlock();
    test_gaps_resync();
    test_saturation();
    test_back_to_back();
    @(negedge clk);
    checks++;
    if ((qa.size() != 0) || (qb.size() != 0)) begin
      errors++; $display("FAIL queue_drain got a=%0d b=%0d want 0 0", qa.size(), qb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
